// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over 32 cycles, with early exit for divide-by-zero and signed overflow.
//
//   state   | meaning
//   IDLE    | waiting for md_start
//   CALC    | running the 32 iterations
//   DONE    | md_done/md_result valid for one cycle
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_funct3,
    input  logic [31:0] md_op_a,
    input  logic [31:0] md_op_b,
    input  logic [4:0]  md_rd_addr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_result,
    output logic [4:0]  md_wrt_addr,
    output logic        md_wrt_en
);
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [2:0]  func_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;

    logic        a_signed;
    logic        b_signed;
    logic        sign_a_in;
    logic        sign_b_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_result;

    always_comb begin
        a_signed  = (md_funct3 == 3'b001) || (md_funct3 == 3'b010) ||
                    (md_funct3 == 3'b100) || (md_funct3 == 3'b110);
        b_signed  = (md_funct3 == 3'b001) || (md_funct3 == 3'b100) ||
                    (md_funct3 == 3'b110);
        sign_a_in = a_signed & md_op_a[31];
        sign_b_in = b_signed & md_op_b[31];
        a_mag_in  = sign_a_in ? -md_op_a : md_op_a;
        b_mag_in  = sign_b_in ? -md_op_b : md_op_b;
        div_zero  = md_funct3[2] && (md_op_b == 32'd0);
        div_ovf   = md_funct3[2] && !md_funct3[0] &&
                    (md_op_a == 32'h8000_0000) && (md_op_b == 32'hFFFF_FFFF);
        if (div_zero)
            special_result = md_funct3[1] ? md_op_a : 32'hFFFF_FFFF;
        else
            special_result = md_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] acc_nxt;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!func_q[2])
            acc_nxt = {mul_sum, acc_q[31:1]};
        else if (!div_diff[32])
            acc_nxt = {div_diff[31:0], acc_q[30:0], 1'b1};
        else
            acc_nxt = {div_shift[31:0], acc_q[30:0], 1'b0};
    end

    logic        neg_res;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_result;

    always_comb begin
        neg_res = sign_a_q ^ sign_b_q;
        prod    = neg_res ? -acc_nxt : acc_nxt;
        quo     = neg_res ? -acc_nxt[31:0] : acc_nxt[31:0];
        rem     = sign_a_q ? -acc_nxt[63:32] : acc_nxt[63:32];
        case (func_q)
            3'b000:                 fix_result = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[63:32];
            3'b100, 3'b101:         fix_result = quo;
            default:                fix_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 6'd0;
            func_q      <= 3'd0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            b_q         <= 32'd0;
            acc_q       <= 64'd0;
            md_busy     <= 1'b0;
            md_done     <= 1'b0;
            md_result   <= 32'd0;
            md_wrt_addr <= 5'd0;
            md_wrt_en   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        func_q      <= md_funct3;
                        md_wrt_addr <= md_rd_addr;
                        sign_a_q    <= sign_a_in;
                        sign_b_q    <= sign_b_in;
                        b_q         <= b_mag_in;
                        acc_q       <= {32'd0, a_mag_in};
                        md_busy     <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state     <= ST_DONE;
                            cnt       <= 6'd0;
                            md_done   <= 1'b1;
                            md_result <= special_result;
                            md_wrt_en <= (md_rd_addr != 5'd0);
                        end else begin
                            state <= ST_CALC;
                            cnt   <= 6'd32;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_nxt;
                    cnt   <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state     <= ST_DONE;
                        md_done   <= 1'b1;
                        md_result <= fix_result;
                        md_wrt_en <= (md_wrt_addr != 5'd0);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    md_done   <= 1'b0;
                    md_wrt_en <= 1'b0;
                    md_busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors plus randomized
// operations compared with an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [2:0]  md_funct3;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic [4:0]  md_rd_addr;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_wrt_addr;
    logic        md_wrt_en;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_funct3(md_funct3),
        .md_op_a(md_op_a), .md_op_b(md_op_b), .md_rd_addr(md_rd_addr),
        .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
        .md_wrt_addr(md_wrt_addr), .md_wrt_en(md_wrt_en)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit and int arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        sa = a;
        sb = b;
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one op and reports what the DUT showed; latency counts edges from the accept edge
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output logic we, output logic [4:0] wa, output logic busy1,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        md_funct3 = f; md_op_a = a; md_op_b = b; md_rd_addr = rd; md_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_start = 1'b0;
        md_funct3 = 3'($urandom); md_op_a = $urandom; md_op_b = $urandom;
        md_rd_addr = 5'($urandom);
        busy1 = md_busy;
        lat = 1;
        while (!md_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = md_result; we = md_wrt_en; wa = md_wrt_addr;
        @(negedge clk);
        done_after = md_done; busy_after = md_busy;
    endtask

    task automatic test_reset;
        reset = 1'b1; md_start = 1'b0; md_funct3 = 3'd0; md_op_a = 32'd0; md_op_b = 32'd0;
        md_rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", md_busy); end
        n_cmp++; if (md_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", md_done); end
        n_cmp++; if (md_result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", md_result); end
        n_cmp++; if (md_wrt_addr !== 5'd0) begin n_err++; $display("FAIL reset_wrt_addr got %0d want 0", md_wrt_addr); end
        n_cmp++; if (md_wrt_en !== 1'b0) begin n_err++; $display("FAIL reset_wrt_en got %b want 0", md_wrt_en); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  tf [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd4};
        logic [31:0] ta [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
                                 32'h8000_0000, 32'h8000_0000, 32'd3, 32'd9};
        logic [31:0] tb [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd4, 32'd0};
        logic [31:0] tr [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                                 32'h1234, 32'h8000_0000, 32'd0, 32'd12, 32'hFFFF_FFFF};
        int          tl [14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 1};
        logic [4:0]  trd [14] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd11, 5'd12, 5'd0, 5'd0};
        logic [31:0] res; int lat; logic we, b1, da, ba; logic [4:0] wa;
        for (int i = 0; i < 14; i++) begin
            run_op(tf[i], ta[i], tb[i], trd[i], res, lat, we, wa, b1, da, ba);
            n_cmp++; if (res !== tr[i]) begin n_err++; $display("FAIL dir%0d_result got %h want %h", i, res, tr[i]); end
            n_cmp++; if (lat !== tl[i]) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tl[i]); end
            n_cmp++; if (we !== (trd[i] != 0)) begin n_err++; $display("FAIL dir%0d_wrt_en got %b want %b", i, we, trd[i] != 0); end
            n_cmp++; if (wa !== trd[i]) begin n_err++; $display("FAIL dir%0d_wrt_addr got %0d want %0d", i, wa, trd[i]); end
            n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy got %b want 1", i, b1); end
            n_cmp++; if (da !== 1'b0 || ba !== 1'b0) begin n_err++; $display("FAIL dir%0d_after_done done=%b busy=%b want 0 0", i, da, ba); end
        end
    endtask

    function automatic logic [31:0] pick_operand(input int sel);
        case (sel)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [31:0] res, a, b, exp_r; int lat, exp_l; logic we, b1, da, ba; logic [4:0] wa, rd;
        logic [2:0] f;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand($urandom_range(0, 7));
            b = pick_operand($urandom_range(0, 7));
            rd = 5'($urandom);
            exp_r = ref_result(f, a, b);
            exp_l = ref_latency(f, a, b);
            run_op(f, a, b, rd, res, lat, we, wa, b1, da, ba);
            n_cmp++; if (res !== exp_r) begin n_err++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, exp_r); end
            n_cmp++; if (lat !== exp_l) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_l); end
            n_cmp++; if (we !== (rd != 0) || wa !== rd) begin n_err++; $display("FAIL rnd%0d_wrt got en=%b addr=%0d want en=%b addr=%0d", i, we, wa, rd != 0, rd); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp1, exp2; int lat;
        exp1 = ref_result(3'd0, 32'd12345, 32'd678);
        exp2 = ref_result(3'd5, 32'd1000000, 32'd37);
        @(negedge clk);
        md_funct3 = 3'd0; md_op_a = 32'd12345; md_op_b = 32'd678; md_rd_addr = 5'd3; md_start = 1'b1;
        @(posedge clk);
        @(negedge clk); md_start = 1'b0; lat = 1;
        repeat (9) @(negedge clk);
        lat += 9;
        md_funct3 = 3'd4; md_op_a = 32'd99; md_op_b = 32'd0; md_rd_addr = 5'd9; md_start = 1'b1;
        @(negedge clk); md_start = 1'b0; lat++;
        while (!md_done && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", lat); end
        n_cmp++; if (md_result !== exp1) begin n_err++; $display("FAIL b2b_first_result got %h want %h", md_result, exp1); end
        n_cmp++; if (md_wrt_addr !== 5'd3) begin n_err++; $display("FAIL b2b_wrt_addr got %0d want 3", md_wrt_addr); end
        // start held from the DONE cycle: ignored at E33, accepted at E34
        md_funct3 = 3'd5; md_op_a = 32'd1000000; md_op_b = 32'd37; md_rd_addr = 5'd4; md_start = 1'b1;
        @(negedge clk);
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got %b want 0", md_busy); end
        @(negedge clk); md_start = 1'b0; lat = 1;
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy got %b want 1", md_busy); end
        while (!md_done && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
        n_cmp++; if (md_result !== exp2) begin n_err++; $display("FAIL b2b_second_result got %h want %h", md_result, exp2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] res; int lat; logic we, b1, da, ba; logic [4:0] wa; int seen;
        @(negedge clk);
        md_funct3 = 3'd1; md_op_a = 32'hDEAD_BEEF; md_op_b = 32'h1234_5678; md_rd_addr = 5'd7; md_start = 1'b1;
        @(posedge clk);
        @(negedge clk); md_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", md_busy); end
        n_cmp++; if (md_result !== 32'd0 || md_wrt_addr !== 5'd0) begin n_err++; $display("FAIL rstmid_outputs got res=%h addr=%0d want 0 0", md_result, md_wrt_addr); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (md_done) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_no_done got %0d pulses want 0", seen); end
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd15, res, lat, we, wa, b1, da, ba);
        n_cmp++; if (res !== ref_result(3'd6, 32'hFFFF_FF00, 32'd7)) begin n_err++; $display("FAIL rstmid_after_result got %h want %h", res, ref_result(3'd6, 32'hFFFF_FF00, 32'd7)); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rstmid_after_latency got %0d want 33", lat); end
    endtask

    task automatic test_rd_zero;
        logic [31:0] res; int lat; logic we, b1, da, ba; logic [4:0] wa;
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd0, res, lat, we, wa, b1, da, ba);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rd0_done got latency %0d want 33", lat); end
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rd0_wrt_en got %b want 0", we); end
        n_cmp++; if (res !== 32'd1) begin n_err++; $display("FAIL rd0_result got %h want 1", res); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_rd_zero;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It takes rs1/rs2 operand values from the register file read ports and produces a 32-bit result plus a one-cycle write request for the register file write port (rd). The core sequences stall on `md_busy`. Each operation takes one accept cycle plus 32 iteration cycles; division by zero and signed overflow complete early.

## Interface
- No parameters. Data width is fixed at 32 bits (RV32M).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `md_start`  in  1  request to begin an operation; sampled only in IDLE.
- `md_funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `md_op_a`  in  32  rs1 value (dividend / multiplicand).
- `md_op_b`  in  32  rs2 value (divisor / multiplier).
- `md_rd_addr`  in  5  destination register, captured with the operands.
- `md_busy`  out  1  high in CALC and DONE states.
- `md_done`  out  1  one-cycle pulse; `md_result` is valid while it is high.
- `md_result`  out  32  registered result; held until the next accepted start.
- `md_wrt_addr`  out  5  captured rd.
- `md_wrt_en`  out  1  equals `md_done` AND (`md_wrt_addr` != 0).

## Operation
- **FSM states:** IDLE, CALC, DONE.
  - IDLE → CALC on `md_start`.
  - IDLE → DONE directly on `md_start` for a special case (see below).
  - CALC → DONE when the iteration counter expires.
  - DONE → IDLE unconditionally.
- **Accept (IDLE with `md_start`=1):**
  - Capture funct3 and rd.
  - Capture operand magnitudes and sign flags:
    - op_a is signed for MULH, MULHSU, DIV, REM.
    - op_b is signed for MULH, DIV, REM.
  - Load the iteration counter with 32.
- `md_start` in CALC or DONE is ignored; inputs may change freely after accept.
- **Multiply:** unsigned shift-add of the magnitudes over 32 iterations into a 64-bit accumulator.
  - Negate the 64-bit product if the sign flags differ.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- **Divide:** restoring division of the magnitudes, one quotient bit per iteration.
  - Quotient is negated if the sign flags differ (DIV only).
  - Remainder takes the sign of op_a (REM only).
- **Special cases** (decided at accept; no iterations; go straight to DONE):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Multiplies have no special cases.
- Sign fix-up and result selection happen on the edge leaving CALC. `md_result` is registered and stable throughout DONE.

## Timing
- **Reset values:** state IDLE, `md_busy`=0, `md_done`=0, `md_result`=0, `md_wrt_addr`=0, `md_wrt_en`=0, counter=0.
- **Normal latency:**
  - Start is sampled at edge E0.
  - Iterations run on E1–E32.
  - `md_done` is high for the cycle after E32 (33 edges after start).
  - Back in IDLE after E33; a new start is accepted at E34 at the earliest.
- **Special-case latency:** `md_done` is high in the cycle after E0; IDLE after E1.
- `md_busy` rises the cycle after the accepting edge and falls the cycle after DONE.
- **Reset mid-operation:** abort immediately; no `md_done` pulse; outputs return to reset values.
- `md_wrt_en` never asserts for rd=0 (x0 stays zero); `md_done` still pulses in that case.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `md_result`=0xFFFFFFEB; `md_done` 33 edges after start; `md_wrt_en`=1 with rd=5.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF and REM 0x1234 / 0 → 0x1234, each with `md_done` 1 edge after start.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both early exit.
- Second start pulsed during CALC is ignored, and the first result is unchanged.
- Reset asserted at iteration 10 → no `md_done`; a new op afterwards completes correctly.
- rd=0 → `md_done`=1 with `md_wrt_en`=0.
